memory: RTL and testbench

MEMORY -- requirements
Module: memory

---
 rtl/memory_if.sv | 16 +
 rtl/memory.sv | 38 +++
 tb/tb_memory.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/memory_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_if : request bundle (address, read/write strobes) for memory  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface memory_if #(
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] addr;
   logic                  write;
   logic                  read;

   modport master (output addr, output write, output read);
   modport slave  (input  addr, input  write, input  read);
endinterface
`default_nettype wire

// File: rtl/memory.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory : single-port RAM on a shared tri-state data bus, async clear |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module memory #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   memory_if.slave                    bus,
   inout  wire       [DATA_WIDTH-1:0] data
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic                  w_wr_en;
   logic                  w_rd_en;

   // A simultaneous read+write request is treated as no operation at all.
   assign w_wr_en = bus.write & ~bus.read;
   assign w_rd_en = bus.read & ~bus.write & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_mem[bus.addr] <= data;
      end
   end

   // Only drive the bus for a clean read, so an external writer never contends.
   assign data = w_rd_en ? r_mem[bus.addr] : {DATA_WIDTH{1'bz}};
endmodule
`default_nettype wire

// File: tb/tb_memory.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_memory : directed + randomized checks of memory against a model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_memory;
   localparam int DW = 8;
   localparam int AW = 8;
   // Undriven bus floats high through the tri1 net, so "released" reads as all ones.
   localparam logic [DW-1:0] c_float = '1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          drv_en = 1'b0;
   logic [DW-1:0] drv_val = '0;
   tri1  [DW-1:0] data;

   logic [DW-1:0] model [2**AW];
   int            n_tests = 0;
   int            n_fail = 0;

   memory_if #(.ADDR_WIDTH(AW)) bus ();

   memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .data  (data)
   );

   assign data = drv_en ? drv_val : {DW{1'bz}};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 2**AW; i++) model[i] = '0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] v);
      @(negedge clk);
      bus.addr = a; bus.read = 1'b0; bus.write = 1'b1;
      drv_val = v; drv_en = 1'b1;
      @(posedge clk);
      #1;
      bus.write = 1'b0; drv_en = 1'b0;
      if (rst_n) model[a] = v;
   endtask

   task automatic do_read(input string tag, input logic [AW-1:0] a);
      @(negedge clk);
      bus.addr = a; bus.write = 1'b0; bus.read = 1'b1; drv_en = 1'b0;
      #1;
      chk(tag, data, model[a]);
      bus.read = 1'b0;
   endtask

   initial begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rv;
      int            op;

      clear_model();
      bus.addr = '0; bus.write = 1'b0; bus.read = 1'b0;

      // Reset state: bus released even with read asserted, memory cleared.
      bus.read = 1'b1; bus.addr = 8'h03;
      #12;
      chk("reset_bus_z", data, c_float);
      bus.read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      do_read("reset_read0", 8'h00);

      // Fill: addr i <- i*3, one write per two cycles, then read back.
      for (int i = 0; i < 16; i++) begin
         do_write(AW'(i), DW'(i * 3));
         @(posedge clk);
      end
      for (int i = 0; i < 16; i++) begin
         do_read($sformatf("fill_rd%0d", i), AW'(i));
      end

      // One-cycle reset pulse clears everything.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      clear_model();
      for (int i = 0; i < 16; i++) begin
         do_read($sformatf("clr_rd%0d", i), AW'(i));
      end

      // Simultaneous read+write: bus stays released, no write happens.
      do_write(8'h05, 8'h77);
      @(negedge clk);
      bus.addr = 8'h05; bus.read = 1'b1; bus.write = 1'b1; drv_en = 1'b0;
      #1;
      chk("both_bus_z", data, c_float);
      @(posedge clk);
      #1;
      bus.read = 1'b0; bus.write = 1'b0;
      do_read("both_mem5", 8'h05);

      // Idle bus, then write-only: only the external value appears.
      @(negedge clk);
      bus.addr = 8'h05; bus.read = 1'b0; bus.write = 1'b0;
      #1;
      chk("idle_bus_z", data, c_float);
      bus.write = 1'b1; drv_val = 8'h5A; drv_en = 1'b1;
      #1;
      chk("wr_only_bus", data, 8'h5A);
      @(posedge clk);
      #1;
      bus.write = 1'b0; drv_en = 1'b0;
      model[5] = 8'h5A;
      do_read("wr_only_mem5", 8'h05);

      // Async reset between edges during a write: cleared with no clock edge.
      do_write(8'h10, 8'h33);
      do_read("pre_async_10", 8'h10);
      @(negedge clk);
      bus.addr = 8'h10; bus.write = 1'b1; drv_val = 8'h99; drv_en = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      bus.write = 1'b0; drv_en = 1'b0;
      rst_n = 1'b1;
      bus.read = 1'b1;
      clear_model();
      #1;
      chk("async_clr_10", data, 8'h00);
      bus.read = 1'b0;

      // Top address.
      do_write(8'h00, 8'h3C);
      do_write(8'hFF, 8'hA5);
      do_read("top_ff", 8'hFF);
      do_read("top_00", 8'h00);

      // Randomized mix against the model.
      for (int k = 0; k < 300; k++) begin
         op = int'($urandom_range(0, 3));
         ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
         rv = DW'($urandom_range(0, 254));
         case (op)
            0: do_write(ra, rv);
            1: do_read("rnd_read", ra);
            2: begin
               @(negedge clk);
               bus.addr = ra; bus.read = 1'b1; bus.write = 1'b1; drv_en = 1'b0;
               #1;
               chk("rnd_both_z", data, c_float);
               @(posedge clk);
               #1;
               bus.read = 1'b0; bus.write = 1'b0;
            end
            default: begin
               @(negedge clk);
               bus.addr = ra; bus.read = 1'b0; bus.write = 1'b0;
               #1;
               chk("rnd_idle_z", data, c_float);
            end
         endcase
      end
      for (int i = 0; i < 32; i++) begin
         do_read("rnd_final", AW'(i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
